// File: rtl/gate_check_pkg.sv
// -----------------------------------------------------------------------------
// gate_check_pkg
// Shared definitions for the gate truth-table sequencer:
//   - gate_sel codes for the six supported 2-input gates
//   - first reserved gate_sel code (codes at or above it are rejected)
//   - sequencer state encoding
//   - width of the per-run mismatch counter
// -----------------------------------------------------------------------------
package gate_check_pkg;

   // Gate type codes presented on gate_sel
   localparam logic [2:0] GATE_AND  = 3'd0;
   localparam logic [2:0] GATE_OR   = 3'd1;
   localparam logic [2:0] GATE_NAND = 3'd2;
   localparam logic [2:0] GATE_NOR  = 3'd3;
   localparam logic [2:0] GATE_XOR  = 3'd4;
   localparam logic [2:0] GATE_XNOR = 3'd5;

   // Codes from this value upward are reserved and never start a run
   localparam logic [2:0] GATE_RSVD_MIN = 3'd6;

   // Mismatch counter width: holds 0..4
   localparam int unsigned ERR_W = 3;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   // True when the select code names a supported gate
   function automatic logic gate_sel_legal(input logic [2:0] sel);
      gate_sel_legal = (sel < GATE_RSVD_MIN);
   endfunction

endpackage

// File: rtl/gate_ref_model.sv
// -----------------------------------------------------------------------------
// gate_ref_model
// Combinational golden reference for the gate under test.
// Ports:
//   gate_sel  in  3  gate type code (gate_check_pkg GATE_*)
//   in1       in  1  first gate input
//   in2       in  1  second gate input
//   expected  out 1  output the named gate must produce for {in1,in2}
// Reserved codes yield 0; the sequencer never samples with a reserved code.
// -----------------------------------------------------------------------------
module gate_ref_model
   import gate_check_pkg::*;
(
   input  logic [2:0] gate_sel,
   input  logic       in1,
   input  logic       in2,
   output logic       expected
);

   // Truth-table lookup for the selected gate
   always_comb begin
      expected = 1'b0;
      case (gate_sel)
         GATE_AND:  expected = in1 & in2;
         GATE_OR:   expected = in1 | in2;
         GATE_NAND: expected = ~(in1 & in2);
         GATE_NOR:  expected = ~(in1 | in2);
         GATE_XOR:  expected = in1 ^ in2;
         GATE_XNOR: expected = ~(in1 ^ in2);
         default:   expected = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_truth_sequencer.sv
// -----------------------------------------------------------------------------
// gate_truth_sequencer
// Drives one 2-input gate through vectors 00, 01, 10, 11, holds each for
// SETTLE cycles, samples the gate output on the last cycle of each hold and
// compares it with gate_ref_model for the gate type latched at start.
//
// Parameter:
//   SETTLE     cycles each vector is held before sampling (1..15)
// Ports:
//   clk        in  1  clock, rising edge
//   rst_n      in  1  synchronous active-low reset
//   start      in  1  begin a run (accepted in IDLE with a legal gate_sel)
//   gate_sel   in  3  gate type under test
//   gate_out   in  1  output of the gate under test
//   in1        out 1  gate input 1 (vector MSB)
//   in2        out 1  gate input 2 (vector LSB)
//   busy       out 1  run in progress
//   done       out 1  one-cycle end-of-run pulse
//   pass       out 1  last completed run had zero mismatches
//   err_count  out 3  mismatches in last/current run
//   fail_mask  out 4  bit k set when vector k mismatched
//
// Build option GATE_CHECK_FAILMASK_EN: when defined, fail_mask records the
// mismatching vector indices; otherwise it is constant zero.
// -----------------------------------------------------------------------------
module gate_truth_sequencer
   import gate_check_pkg::*;
#(
   parameter int unsigned SETTLE = 2
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       gate_sel,
   input  logic             gate_out,
   output logic             in1,
   output logic             in2,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       fail_mask
);

   // Last count value of a vector hold; sampling happens when cnt_r hits it
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   seq_state_e       state_r;
   logic [2:0]       sel_r;
   logic [1:0]       vec_r;
   logic [3:0]       cnt_r;

   logic             expected_s;
   logic             accept_s;
   logic             sample_s;
   logic             mismatch_s;
   logic [ERR_W-1:0] err_next_s;

   // Reference sees the latched gate type and the vector currently driven
   gate_ref_model u_ref (
      .gate_sel (sel_r),
      .in1      (vec_r[1]),
      .in2      (vec_r[0]),
      .expected (expected_s)
   );

   // Start acceptance, sample strobe and next mismatch count
   always_comb begin
      accept_s   = 1'b0;
      sample_s   = 1'b0;
      mismatch_s = 1'b0;
      err_next_s = err_count;
      if ((state_r == IDLE) && start && gate_sel_legal(gate_sel)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      if ((state_r == RUN) && (cnt_r == SETTLE_LAST)) begin
         sample_s = 1'b1;
      end else begin
         sample_s = 1'b0;
      end
      mismatch_s = sample_s & (gate_out != expected_s);
      if (mismatch_s) begin
         err_next_s = err_count + 3'd1;
      end else begin
         err_next_s = err_count;
      end
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         sel_r     <= GATE_AND;
         vec_r     <= 2'd0;
         cnt_r     <= 4'd0;
         in1       <= 1'b0;
         in2       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= 3'd0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (accept_s) begin
                  state_r   <= RUN;
                  sel_r     <= gate_sel;
                  vec_r     <= 2'd0;
                  cnt_r     <= 4'd0;
                  in1       <= 1'b0;
                  in2       <= 1'b0;
                  busy      <= 1'b1;
                  pass      <= 1'b0;
                  err_count <= 3'd0;
               end
            end
            RUN: begin
               err_count <= err_next_s;
               if (sample_s) begin
                  cnt_r <= 4'd0;
                  if (vec_r == 2'd3) begin
                     // Last vector checked: close the run
                     state_r <= DONE;
                     vec_r   <= 2'd0;
                     in1     <= 1'b0;
                     in2     <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     pass    <= (err_next_s == 3'd0);
                  end else begin
                     vec_r      <= vec_r + 2'd1;
                     {in1, in2} <= vec_r + 2'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            DONE: begin
               done    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               vec_r   <= 2'd0;
               cnt_r   <= 4'd0;
               in1     <= 1'b0;
               in2     <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

`ifdef GATE_CHECK_FAILMASK_EN
   // Per-vector failure record, cleared when a run is accepted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fail_mask <= 4'b0000;
      end else if (accept_s) begin
         fail_mask <= 4'b0000;
      end else if (mismatch_s) begin
         fail_mask[vec_r] <= 1'b1;
      end else begin
         fail_mask <= fail_mask;
      end
   end
`else
   assign fail_mask = 4'b0000;
`endif

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gate_truth_sequencer
// Two sequencers (SETTLE=2 and SETTLE=1) each loop back through a behavioural
// gate described by a 4-entry output table. Expected results come from the
// gate truth tables: a vector mismatches when the looped gate's table entry
// differs from the selected gate's truth-table entry.
// -----------------------------------------------------------------------------
module tb_gate_truth_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start     [2];
   logic [2:0] gate_sel  [2];
   logic       gate_out  [2];
   logic       in1_w     [2];
   logic       in2_w     [2];
   logic       busy_w    [2];
   logic       done_w    [2];
   logic       pass_w    [2];
   logic [2:0] err_w     [2];
   logic [3:0] mask_w    [2];

   // Behaviour of the gate wired into each loop: bit k = output for vector k
   logic [3:0] gate_tt   [2];

   int vectors     = 0;
   int miscompares = 0;
   int last_err    [2];
   int last_pass   [2];

   always #5 clk = ~clk;

   // Looped-back gates are purely combinational
   always_comb begin
      gate_out[0] = gate_tt[0][{in1_w[0], in2_w[0]}];
      gate_out[1] = gate_tt[1][{in1_w[1], in2_w[1]}];
   end

   gate_truth_sequencer #(.SETTLE(2)) u_dut_s2 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .gate_sel(gate_sel[0]),
      .gate_out(gate_out[0]), .in1(in1_w[0]), .in2(in2_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .err_count(err_w[0]), .fail_mask(mask_w[0])
   );

   gate_truth_sequencer #(.SETTLE(1)) u_dut_s1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .gate_sel(gate_sel[1]),
      .gate_out(gate_out[1]), .in1(in1_w[1]), .in2(in2_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .err_count(err_w[1]), .fail_mask(mask_w[1])
   );

   // Output column of each gate's truth table, bit k = vector {in1,in2}=k
   function automatic logic [3:0] truth(input int sel);
      case (sel)
         0: truth = 4'b1000;  // AND
         1: truth = 4'b1110;  // OR
         2: truth = 4'b0111;  // NAND
         3: truth = 4'b0001;  // NOR
         4: truth = 4'b0110;  // XOR
         5: truth = 4'b1001;  // XNOR
         default: truth = 4'b0000;
      endcase
   endfunction

   function automatic int popc(input logic [3:0] m);
      popc = 0;
      for (int i = 0; i < 4; i++) popc += int'(m[i]);
   endfunction

   function automatic logic [3:0] mask_expect(input logic [3:0] m);
`ifdef GATE_CHECK_FAILMASK_EN
      mask_expect = m;
`else
      mask_expect = 4'b0000;
`endif
   endfunction

   function automatic int settle_of(input int d);
      settle_of = (d == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input int d);
      chk("rst_in1",  32'(in1_w[d]),  32'd0);
      chk("rst_in2",  32'(in2_w[d]),  32'd0);
      chk("rst_busy", 32'(busy_w[d]), 32'd0);
      chk("rst_done", 32'(done_w[d]), 32'd0);
      chk("rst_pass", 32'(pass_w[d]), 32'd0);
      chk("rst_err",  32'(err_w[d]),  32'd0);
      chk("rst_mask", 32'(mask_w[d]), 32'd0);
   endtask

   // One full run; optional disturbance re-pulses start with another select
   task automatic run(input int d, input int sel, input logic [3:0] looped,
                      input int disturb_cycle, input int alt_sel);
      int s;
      int nk;
      logic [3:0] miss;
      logic [3:0] seen;
      s    = settle_of(d);
      miss = truth(sel) ^ looped;
      gate_tt[d] = looped;
      @(negedge clk);
      start[d]    = 1'b1;
      gate_sel[d] = 3'(sel);
      for (int c = 0; c < 4 * s; c++) begin
         @(negedge clk);
         if (c == disturb_cycle) begin
            start[d]    = 1'b1;
            gate_sel[d] = 3'(alt_sel);
         end else begin
            start[d] = 1'b0;
         end
         nk   = c / s;
         seen = miss & 4'((1 << nk) - 1);
         chk("run_in1",  32'(in1_w[d]),  32'((nk >> 1) & 1));
         chk("run_in2",  32'(in2_w[d]),  32'(nk & 1));
         chk("run_busy", 32'(busy_w[d]), 32'd1);
         chk("run_done", 32'(done_w[d]), 32'd0);
         chk("run_pass", 32'(pass_w[d]), 32'd0);
         chk("run_err",  32'(err_w[d]),  32'(popc(seen)));
         chk("run_mask", 32'(mask_w[d]), 32'(mask_expect(seen)));
      end
      @(negedge clk);
      start[d] = 1'b0;
      chk("end_done", 32'(done_w[d]), 32'd1);
      chk("end_busy", 32'(busy_w[d]), 32'd0);
      chk("end_in",   32'({in1_w[d], in2_w[d]}), 32'd0);
      chk("end_pass", 32'(pass_w[d]), 32'(miss == 4'b0000));
      chk("end_err",  32'(err_w[d]),  32'(popc(miss)));
      chk("end_mask", 32'(mask_w[d]), 32'(mask_expect(miss)));
      @(negedge clk);
      chk("post_done", 32'(done_w[d]), 32'd0);
      chk("post_err",  32'(err_w[d]),  32'(popc(miss)));
      chk("post_mask", 32'(mask_w[d]), 32'(mask_expect(miss)));
      last_err[d]  = popc(miss);
      last_pass[d] = int'(miss == 4'b0000);
   endtask

   initial begin
      logic [3:0] flips;
      int d;
      int sel;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start[i]    = 1'b0;
         gate_sel[i] = 3'd0;
         gate_tt[i]  = 4'b0000;
         last_err[i] = 0;
         last_pass[i] = 0;
      end
      repeat (3) @(negedge clk);
      chk_reset_values(0);
      chk_reset_values(1);
      rst_n = 1'b1;

      // AND loop, SETTLE=2, correct gate
      run(0, 0, truth(0), -1, 0);
      // AND select with output stuck at 1
      run(0, 0, 4'b1111, -1, 0);

      // All six gate types, SETTLE=1, correct gates
      for (int g = 0; g < 6; g++) run(1, g, truth(g), -1, 0);

      // Reserved select: ignored, previous results held
      @(negedge clk);
      start[0]    = 1'b1;
      gate_sel[0] = 3'd6;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         start[0] = 1'b0;
         chk("rsvd_busy", 32'(busy_w[0]), 32'd0);
         chk("rsvd_done", 32'(done_w[0]), 32'd0);
      end
      chk("rsvd_err",  32'(err_w[0]),  32'(last_err[0]));
      chk("rsvd_pass", 32'(pass_w[0]), 32'(last_pass[0]));

      // Restart attempt and select change at cycle 3: NAND stays latched
      run(0, 2, truth(2) ^ 4'b0100, 3, 4);

      // Reset for one cycle at cycle 5 of a run
      gate_tt[0] = truth(1) ^ 4'b0001;
      @(negedge clk);
      start[0]    = 1'b1;
      gate_sel[0] = 3'd1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         start[0] = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_values(0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("rstmid_done", 32'(done_w[0]), 32'd0);
         chk("rstmid_busy", 32'(busy_w[0]), 32'd0);
      end
      run(0, 1, truth(1), -1, 0);

      // Randomized runs with random injected gate faults
      for (int r = 0; r < 16; r++) begin
         d     = int'($urandom_range(0, 1));
         sel   = int'($urandom_range(0, 5));
         flips = (r % 4 == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         run(d, sel, truth(sel) ^ flips, -1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
